bmp_master_rx: RTL and testbench
================================

# bmp_master_rx

Master-side receiver for the BMP stream that the scheduler drives onto its master port. It accepts 32-bit beats under a ready/valid handshake and captures the 56-byte header region. It decodes signature, file size and pixel-data offset, then writes the payload words to a word-addressed image memory with byte enables. It flags completion, and flags protocol errors: bad signature, short/over-long file, source switch mid-file, and early completion.

## Interface
Parameters:
- DATA_BUS_SIZE, 32, beat width; only 32 is supported (4 bytes/beat).
- ADDR_W, 16, image-memory word-address width.
- HDR_BYTES, 56, header region length in bytes (54-byte BMP header + 2 pad bytes), always 14 beats.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- mstr_data_valid  in  2  [0] beat valid, [1] source slave id.
- data_in  in  DATA_BUS_SIZE  beat data; byte k = data_in[8k+7:8k] (little-endian).
- mstr_cmplt  in  1  transmitter's end-of-file indication.
- mstr_ready  out  1  receiver can accept a beat.
- mem_full  in  1  image memory cannot take a write.
- clr  in  1  synchronous clear of error state/flags.
- mem_wr  out  1  write strobe.
- mem_addr  out  ADDR_W  payload word address, 0-based.
- mem_wdata  out  DATA_BUS_SIZE  write data.
- mem_be  out  4  byte enables.
- file_size  out  32  header bytes 2..5.
- data_offset  out  32  header bytes 10..13.
- src_id  out  1  slave id captured on word 0.
- bytes_rcvd  out  32  bytes accepted in current file, header included.
- rx_done  out  1  one-cycle pulse, file complete.
- err_sig, err_len, err_src  out  1 each  sticky error flags.

## Operation
- Beat accepted on a rising edge where mstr_data_valid[0] && mstr_ready.
- mstr_ready = rst_n && !mem_full && state != DONE (combinational).
- States: IDLE, HEADER, PAYLOAD, DONE, ERROR. Reset: IDLE, every output 0.
- IDLE: on an accepted beat, treat it as word 0:
  - Capture src_id = mstr_data_valid[1].
  - Set bytes_rcvd = 4.
  - If bytes 0,1 are not 0x42,0x4D ('B','M'), set err_sig and go to ERROR; otherwise go to HEADER.
- HEADER: words 0..13 assemble file_size (word0 bytes 2,3 + word1 bytes 0,1) and data_offset (word2 bytes 2,3 + word3 bytes 0,1).
  - Header words are never written to memory.
  - After word 13, bytes_rcvd = 56.
  - If file_size < 57, or file_size - 56 > 4*2^ADDR_W, set err_len and go to ERROR; otherwise go to PAYLOAD.
- PAYLOAD: each accepted beat is written to mem_addr, which then increments; bytes_rcvd += 4.
  - Remaining bytes R = file_size - bytes_rcvd before the beat.
  - mem_be = 4'b1111 if R >= 4, else (1<<R)-1.
  - The beat that makes bytes_rcvd >= file_size moves the FSM to DONE.
- DONE: rx_done pulses for one cycle, then return to IDLE.
  - file_size, data_offset, src_id and bytes_rcvd hold until the next word 0.
  - mem_addr resets to 0 on the next word 0.
- mstr_cmplt while in HEADER/PAYLOAD: set err_len and go to ERROR. It is ignored in IDLE/DONE.
  - If mstr_cmplt coincides with the final payload beat, the beat wins: no error.
- Source check in HEADER/PAYLOAD: an accepted beat whose mstr_data_valid[1] != src_id sets err_src, goes to ERROR, and is not written.
- ERROR: mstr_ready stays as defined (drain); beats are discarded; no mem writes; flags sticky.
  - clr returns the FSM to IDLE and clears err_* and bytes_rcvd.
  - clr in other states clears flags only.
- mem_full rising mid-file stalls via mstr_ready only; no state change and no data loss.

## Timing
- Registered write path: beat accepted at edge N gives mem_wr/mem_addr/mem_wdata/mem_be valid in cycle N+1, i.e. latency 1.
- Accepting one beat per cycle gives 1 write per cycle; mem_wr is a single-cycle pulse per beat.
- file_size is valid from the edge accepting word 1; data_offset from the edge accepting word 3.
- rx_done is high in the cycle after the final beat's edge, coincident with the final mem_wr.
- Error flags assert in the cycle after the offending edge.
- Asynchronous reset mid-file aborts immediately: all outputs go to 0, with no partial write.

## Test plan
- Nominal file: word0=0x0076_4D42, word1=0, word2=0x0036_0000, words3..13=0, then 16 payload beats -> mem_addr 0..15 written, mem_be=4'b1111 except last=4'b0011, file_size=118, data_offset=0x36, rx_done pulse with last write, bytes_rcvd=120.
- Bad signature: word0=0x0076_4D43 -> err_sig=1, ERROR, no mem_wr for remaining beats; clr -> IDLE, flags 0.
- Early completion: same header, mstr_cmplt asserted after payload beat 8 -> err_len=1, only 8 writes observed.
- Source switch: header from id 0, payload beat 3 with mstr_data_valid=2'b11 -> err_src=1, beat 3 not written.
- Backpressure: mem_full high 5 cycles mid-payload with valid held -> mstr_ready=0, no accepts, then resume; all 16 words correct and in order.
- Back-to-back files plus reset: second file word 0 in the cycle after rx_done -> mem_addr restarts at 0; rst_n pulled low mid-payload -> all outputs 0, FSM in IDLE.

Source files
------------

// File: rtl/bmp_master_rx.sv
// bmp_master_rx: master-side receiver for a BMP byte stream.
// Word 0 of a file carries the signature and the low half of the file size.
// The header region (HDR_BYTES, 14 beats) is decoded but never stored. Every
// payload beat after it goes to a word-addressed image memory with byte enables.
//
// Handshake: a beat transfers on a rising clk edge where mstr_data_valid[0]
// and mstr_ready are both high. mstr_data_valid[1] is the source id and is
// only meaningful with [0]. mstr_ready is combinational. It is high out of
// reset unless the image memory is full or the FSM sits in DONE, so ERROR
// still drains beats and then drops them. The producer must hold the beat
// stable until it transfers.
//
// Only a 32-bit beat (4 bytes) is supported. Byte k is data_in[8k+7:8k].
module bmp_master_rx #(
  parameter int DATA_BUS_SIZE = 32,
  parameter int ADDR_W        = 16,
  parameter int HDR_BYTES     = 56
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               mstr_data_valid,
  input  logic [DATA_BUS_SIZE-1:0] data_in,
  input  logic                     mstr_cmplt,
  output logic                     mstr_ready,
  input  logic                     mem_full,
  input  logic                     clr,
  output logic                     mem_wr,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_BUS_SIZE-1:0] mem_wdata,
  output logic [3:0]               mem_be,
  output logic [31:0]              file_size,
  output logic [31:0]              data_offset,
  output logic                     src_id,
  output logic [31:0]              bytes_rcvd,
  output logic                     rx_done,
  output logic                     err_sig,
  output logic                     err_len,
  output logic                     err_src,
  output logic [2:0]               fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HEADER  = 3'd1,
    S_PAYLOAD = 3'd2,
    S_DONE    = 3'd3,
    S_ERROR   = 3'd4
  } state_t;

  // Index of the last header beat; words 0..HDR_LAST form the header region.
  localparam int          HDR_LAST    = HDR_BYTES / 4 - 1;
  // Largest payload the image memory can hold, in bytes.
  localparam logic [32:0] MAX_PAYLOAD = 33'd4 << ADDR_W;

  state_t state_q, state_d;

  logic [3:0]        hdr_cnt;
  logic [ADDR_W-1:0] wr_ptr;

  // Combinational decode shared by the next-state and datapath logic.
  logic        accept;
  logic        beat_src;
  logic        src_bad;
  logic        in_file;
  logic        word0;
  logic        set_sig;
  logic        hdr_take;
  logic        hdr_last;
  logic        len_bad;
  logic        pay_last;
  logic        pay_final;
  logic        pay_take;
  logic        set_src;
  logic        set_len;
  logic [3:0]  be_d;
  logic [31:0] remaining;
  logic [32:0] payload_len;

  assign fsm_state = state_q;

  // Arithmetic on the captured header fields.
  assign remaining   = file_size - bytes_rcvd;
  assign payload_len = {1'b0, file_size} - 33'(HDR_BYTES);
  assign len_bad     = (file_size < 32'(HDR_BYTES + 1)) || (payload_len > MAX_PAYLOAD);
  assign pay_last    = (remaining <= 32'd4);
  assign hdr_last    = (hdr_cnt == 4'(HDR_LAST));

  // Byte enables for a payload beat: only the bytes still owed by the file.
  always_comb begin
    be_d = 4'b1111;
    if (remaining < 32'd4) begin
      case (remaining[1:0])
        2'd1:    be_d = 4'b0001;
        2'd2:    be_d = 4'b0011;
        2'd3:    be_d = 4'b0111;
        default: be_d = 4'b0000;
      endcase
    end
  end

  // State register; asynchronous reset aborts any file in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (word0) begin
          state_d = set_sig ? S_ERROR : S_HEADER;
        end
      end
      S_HEADER: begin
        if (set_src || set_len) begin
          state_d = S_ERROR;
        end else if (hdr_take && hdr_last) begin
          state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        // The final beat beats a simultaneous mstr_cmplt.
        if (pay_final) begin
          state_d = S_DONE;
        end else if (set_src || set_len) begin
          state_d = S_ERROR;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_ERROR: begin
        if (clr) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode: handshake and per-cycle action strobes.
  always_comb begin
    mstr_ready = rst_n && !mem_full && (state_q != S_DONE);
    accept     = mstr_data_valid[0] && mstr_ready;
    beat_src   = mstr_data_valid[1];
    src_bad    = (beat_src != src_id);
    in_file    = (state_q == S_HEADER) || (state_q == S_PAYLOAD);
    word0      = (state_q == S_IDLE) && accept;
    set_sig    = word0 && (data_in[15:0] != 16'h4D42);
    hdr_take   = (state_q == S_HEADER) && accept && !src_bad && !mstr_cmplt;
    pay_final  = (state_q == S_PAYLOAD) && accept && !src_bad && pay_last;
    pay_take   = (state_q == S_PAYLOAD) && accept && !src_bad && (!mstr_cmplt || pay_last);
    set_src    = in_file && accept && src_bad;
    set_len    = (in_file && mstr_cmplt && !pay_final) ||
                 (hdr_take && hdr_last && len_bad);
  end

  // Datapath: header capture, registered memory write, counters and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_be      <= 4'b0000;
      file_size   <= 32'd0;
      data_offset <= 32'd0;
      src_id      <= 1'b0;
      bytes_rcvd  <= 32'd0;
      rx_done     <= 1'b0;
      err_sig     <= 1'b0;
      err_len     <= 1'b0;
      err_src     <= 1'b0;
      hdr_cnt     <= 4'd0;
      wr_ptr      <= '0;
    end else begin
      mem_wr  <= 1'b0;
      rx_done <= pay_final;

      if (clr) begin
        err_sig <= 1'b0;
        err_len <= 1'b0;
        err_src <= 1'b0;
        if (state_q == S_ERROR) begin
          bytes_rcvd <= 32'd0;
        end
      end

      // A new offence in the same cycle as clr still gets recorded.
      if (set_sig) err_sig <= 1'b1;
      if (set_len) err_len <= 1'b1;
      if (set_src) err_src <= 1'b1;

      if (word0) begin
        src_id      <= beat_src;
        bytes_rcvd  <= 32'd4;
        file_size   <= {16'h0000, data_in[31:16]};
        data_offset <= 32'd0;
        hdr_cnt     <= 4'd1;
        wr_ptr      <= '0;
        mem_addr    <= '0;
      end

      if (hdr_take) begin
        bytes_rcvd <= bytes_rcvd + 32'd4;
        hdr_cnt    <= hdr_cnt + 4'd1;
        case (hdr_cnt)
          4'd1:    file_size[31:16]   <= data_in[15:0];
          4'd2:    data_offset[15:0]  <= data_in[31:16];
          4'd3:    data_offset[31:16] <= data_in[15:0];
          default: ;
        endcase
      end

      if (pay_take) begin
        mem_wr     <= 1'b1;
        mem_addr   <= wr_ptr;
        mem_wdata  <= data_in;
        mem_be     <= be_d;
        wr_ptr     <= wr_ptr + ADDR_W'(1);
        bytes_rcvd <= bytes_rcvd + 32'd4;
      end
    end
  end

endmodule

// File: tb/tb_bmp_master_rx.sv
// tb_bmp_master_rx: randomized scenarios for bmp_master_rx.
// A behavioural model turns each file description into the exact memory writes
// it must produce. A negedge monitor checks every write against that queue.
module tb_bmp_master_rx;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_PAYLOAD = 3'd2;
  localparam logic [2:0] ST_ERROR   = 3'd4;

  logic        clk;
  logic        rst_n;
  logic [1:0]  mstr_data_valid;
  logic [31:0] data_in;
  logic        mstr_cmplt;
  logic        mstr_ready;
  logic        mem_full;
  logic        clr;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] file_size;
  logic [31:0] data_offset;
  logic        src_id;
  logic [31:0] bytes_rcvd;
  logic        rx_done;
  logic        err_sig;
  logic        err_len;
  logic        err_src;
  logic [2:0]  fsm_state;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  int done_cnt = 0;
  int done_wr_cnt = 0;

  logic [51:0] exp_q[$];   // {addr, data, be} of every write still owed
  logic [31:0] beats[$];   // the file being sent: header words then payload

  bmp_master_rx #(.DATA_BUS_SIZE(32), .ADDR_W(16), .HDR_BYTES(56)) dut (
    .clk(clk), .rst_n(rst_n), .mstr_data_valid(mstr_data_valid), .data_in(data_in),
    .mstr_cmplt(mstr_cmplt), .mstr_ready(mstr_ready), .mem_full(mem_full), .clr(clr),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .file_size(file_size), .data_offset(data_offset), .src_id(src_id),
    .bytes_rcvd(bytes_rcvd), .rx_done(rx_done), .err_sig(err_sig), .err_len(err_len),
    .err_src(err_src), .fsm_state(fsm_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // Scoreboard: every write must match the head of the expected queue.
  always @(negedge clk) begin
    logic [51:0] e;
    if (mem_wr === 1'b1) begin
      wr_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: addr %0d data %h be %b, required no write", mem_addr, mem_wdata, mem_be);
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata, mem_be} !== e)
          begin n_fail++; $display("FAIL write_content: got addr %0d data %h be %b, required addr %0d data %h be %b", mem_addr, mem_wdata, mem_be, e[51:36], e[35:4], e[3:0]); end
      end
    end
    if (rx_done === 1'b1) begin
      done_cnt++;
      if (mem_wr === 1'b1) done_wr_cnt++;
    end
  end

  // Model: build a file. zero_fill leaves every unused header byte at 0;
  // otherwise those bytes are random so only the decoded fields matter.
  task automatic build_file(input logic [31:0] fs, input logic [31:0] off, input bit zero_fill);
    logic [31:0] r;
    int n;
    beats.delete();
    r = zero_fill ? 32'd0 : $urandom;
    beats.push_back({fs[15:0], 16'h4D42});
    beats.push_back({r[31:16], fs[31:16]});
    beats.push_back({off[15:0], r[15:0]});
    r = zero_fill ? 32'd0 : $urandom;
    beats.push_back({r[31:16], off[31:16]});
    for (int i = 4; i < 14; i++) beats.push_back(zero_fill ? 32'd0 : $urandom);
    n = (fs > 32'd56) ? int'((fs - 32'd53) / 32'd4) : 0;
    if (n > 64) n = 64;
    for (int i = 0; i < n; i++) beats.push_back($urandom);
  endtask

  // Model: expect the first n payload beats written from address 0. A byte is
  // enabled only when it lies inside the file's payload length.
  task automatic expect_writes(input logic [31:0] fs, input int n);
    logic [3:0] be;
    longint plen;
    plen = longint'(fs) - 56;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) be[k] = (longint'(i * 4 + k) < plen);
      exp_q.push_back({16'(i), beats[14 + i], be});
    end
  endtask

  // Driver: present one beat and hold it until it transfers.
  task automatic send_beat(input logic [31:0] d, input logic src, input logic cmplt);
    int waited;
    waited = 0;
    data_in = d;
    mstr_data_valid = {src, 1'b1};
    mstr_cmplt = cmplt;
    #1;
    while (mstr_ready !== 1'b1 && waited < 40) begin
      @(negedge clk); #1;
      waited++;
    end
    if (waited >= 40) begin
      n_checks++; n_fail++;
      $display("FAIL beat_accept_timeout: mstr_ready stuck at %b, required 1 within 40 cycles", mstr_ready);
    end
    @(negedge clk);
    mstr_data_valid = 2'b00;
    mstr_cmplt = 1'b0;
  endtask

  task automatic send_range(input int first, input int last, input logic src);
    for (int i = first; i <= last; i++) send_beat(beats[i], src, 1'b0);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (mstr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b, required 0", mstr_ready); end
    n_checks++; if ({mem_wr, rx_done, err_sig, err_len, err_src, src_id} !== 6'b0) begin n_fail++; $display("FAIL reset_flags: got %b, required 000000", {mem_wr, rx_done, err_sig, err_len, err_src, src_id}); end
    n_checks++; if ({file_size, data_offset, bytes_rcvd} !== 96'd0) begin n_fail++; $display("FAIL reset_fields: got %h %h %h, required all 0", file_size, data_offset, bytes_rcvd); end
    n_checks++; if ({mem_addr, mem_wdata, mem_be} !== 52'd0) begin n_fail++; $display("FAIL reset_mem_port: got %h %h %b, required all 0", mem_addr, mem_wdata, mem_be); end
    n_checks++; if (fsm_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d, required %0d", fsm_state, ST_IDLE); end
    rst_n = 1'b1;
    #1;
    n_checks++; if (mstr_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %b, required 1", mstr_ready); end
  endtask

  task automatic test_nominal();
    int w0, d0, dw0;
    build_file(32'd118, 32'h36, 1'b1);
    expect_writes(32'd118, 16);
    w0 = wr_cnt; d0 = done_cnt; dw0 = done_wr_cnt;
    send_range(0, 13, 1'b0);
    #1;
    n_checks++; if (file_size !== 32'd118) begin n_fail++; $display("FAIL nom_file_size: got %0d, required 118", file_size); end
    n_checks++; if (data_offset !== 32'h36) begin n_fail++; $display("FAIL nom_data_offset: got %h, required 36", data_offset); end
    n_checks++; if (bytes_rcvd !== 32'd56) begin n_fail++; $display("FAIL nom_hdr_bytes: got %0d, required 56", bytes_rcvd); end
    n_checks++; if (wr_cnt != w0) begin n_fail++; $display("FAIL nom_hdr_no_write: got %0d writes, required 0", wr_cnt - w0); end
    send_range(14, 29, 1'b0);
    settle();
    n_checks++; if (wr_cnt - w0 != 16 || exp_q.size() != 0) begin n_fail++; $display("FAIL nom_writes: got %0d writes with %0d owed, required 16 and 0", wr_cnt - w0, exp_q.size()); end
    n_checks++; if (done_cnt - d0 != 1 || done_wr_cnt - dw0 != 1) begin n_fail++; $display("FAIL nom_rx_done: got %0d pulses (%0d with write), required 1 and 1", done_cnt - d0, done_wr_cnt - dw0); end
    n_checks++; if (bytes_rcvd !== 32'd120) begin n_fail++; $display("FAIL nom_bytes_rcvd: got %0d, required 120", bytes_rcvd); end
    n_checks++; if ({err_sig, err_len, err_src} !== 3'b000) begin n_fail++; $display("FAIL nom_errors: got %b, required 000", {err_sig, err_len, err_src}); end
    exp_q.delete();
  endtask

  task automatic test_random_files();
    logic [31:0] fs, off;
    logic src;
    int n, w0, d0;
    for (int r = 0; r < 4; r++) begin
      fs  = 32'($urandom_range(57, 177));
      off = $urandom;
      src = 1'($urandom_range(0, 1));
      build_file(fs, off, 1'b0);
      n = beats.size() - 14;
      expect_writes(fs, n);
      w0 = wr_cnt; d0 = done_cnt;
      send_range(0, 1, src);
      #1;
      n_checks++; if (file_size !== fs || src_id !== src) begin n_fail++; $display("FAIL rnd_size_after_w1: got %0d id %b, required %0d id %b", file_size, src_id, fs, src); end
      send_range(2, 3, src);
      #1;
      n_checks++; if (data_offset !== off) begin n_fail++; $display("FAIL rnd_offset_after_w3: got %h, required %h", data_offset, off); end
      send_range(4, beats.size() - 1, src);
      settle();
      n_checks++; if (wr_cnt - w0 != n || exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_writes: got %0d writes with %0d owed, required %0d and 0", wr_cnt - w0, exp_q.size(), n); end
      n_checks++; if (done_cnt - d0 != 1 || bytes_rcvd !== 32'(56 + 4 * n)) begin n_fail++; $display("FAIL rnd_done: got %0d pulses, bytes %0d, required 1 and %0d", done_cnt - d0, bytes_rcvd, 56 + 4 * n); end
      exp_q.delete();
    end
  endtask

  task automatic test_bad_sig();
    send_beat(32'h0076_4D43, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) send_beat($urandom, 1'b0, 1'b0);
    settle();
    n_checks++; if ({err_sig, err_len, err_src} !== 3'b100) begin n_fail++; $display("FAIL sig_flags: got %b, required 100", {err_sig, err_len, err_src}); end
    n_checks++; if (fsm_state !== ST_ERROR || mstr_ready !== 1'b1) begin n_fail++; $display("FAIL sig_drain: got state %0d ready %b, required %0d and 1", fsm_state, mstr_ready, ST_ERROR); end
    n_checks++; if (bytes_rcvd !== 32'd4) begin n_fail++; $display("FAIL sig_bytes: got %0d, required 4", bytes_rcvd); end
    pulse_clr();
    n_checks++; if ({err_sig, err_len, err_src} !== 3'b000 || fsm_state !== ST_IDLE || bytes_rcvd !== 32'd0) begin n_fail++; $display("FAIL sig_clr: got flags %b state %0d bytes %0d, required 000, %0d, 0", {err_sig, err_len, err_src}, fsm_state, bytes_rcvd, ST_IDLE); end
  endtask

  task automatic test_early_cmplt();
    int w0, d0;
    build_file(32'd118, 32'h36, 1'b0);
    expect_writes(32'd118, 8);
    w0 = wr_cnt; d0 = done_cnt;
    send_range(0, 21, 1'b0);
    mstr_cmplt = 1'b1;
    @(negedge clk);
    mstr_cmplt = 1'b0;
    send_range(22, 25, 1'b0);
    settle();
    n_checks++; if ({err_sig, err_len, err_src} !== 3'b010 || fsm_state !== ST_ERROR) begin n_fail++; $display("FAIL early_flags: got %b state %0d, required 010 and %0d", {err_sig, err_len, err_src}, fsm_state, ST_ERROR); end
    n_checks++; if (wr_cnt - w0 != 8 || exp_q.size() != 0 || done_cnt != d0) begin n_fail++; $display("FAIL early_writes: got %0d writes, %0d owed, %0d done, required 8, 0, 0", wr_cnt - w0, exp_q.size(), done_cnt - d0); end
    exp_q.delete();
    pulse_clr();
  endtask

  task automatic test_src_switch();
    int w0;
    build_file(32'd118, 32'h36, 1'b0);
    expect_writes(32'd118, 3);
    w0 = wr_cnt;
    send_range(0, 16, 1'b0);
    send_beat(beats[17], 1'b1, 1'b0);
    send_range(18, 21, 1'b0);
    settle();
    n_checks++; if ({err_sig, err_len, err_src} !== 3'b001) begin n_fail++; $display("FAIL src_flags: got %b, required 001", {err_sig, err_len, err_src}); end
    n_checks++; if (wr_cnt - w0 != 3 || exp_q.size() != 0) begin n_fail++; $display("FAIL src_writes: got %0d writes, %0d owed, required 3 and 0", wr_cnt - w0, exp_q.size()); end
    exp_q.delete();
    pulse_clr();
  endtask

  task automatic test_backpressure();
    int w0, d0, w_stall;
    build_file(32'd118, 32'h36, 1'b0);
    expect_writes(32'd118, 16);
    w0 = wr_cnt; d0 = done_cnt;
    send_range(0, 18, 1'b0);
    data_in = beats[19];
    mstr_data_valid = 2'b01;
    mem_full = 1'b1;
    #1;
    w_stall = wr_cnt;
    for (int c = 0; c < 5; c++) begin
      n_checks++; if (mstr_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_cycle%0d: got %b, required 0", c, mstr_ready); end
      @(negedge clk); #1;
    end
    n_checks++; if (bytes_rcvd !== 32'd76 || wr_cnt - w_stall > 1) begin n_fail++; $display("FAIL bp_stalled: got bytes %0d, %0d writes, required 76 and at most 1", bytes_rcvd, wr_cnt - w_stall); end
    mem_full = 1'b0;
    send_range(19, 29, 1'b0);
    settle();
    n_checks++; if (wr_cnt - w0 != 16 || exp_q.size() != 0 || done_cnt - d0 != 1) begin n_fail++; $display("FAIL bp_writes: got %0d writes, %0d owed, %0d done, required 16, 0, 1", wr_cnt - w0, exp_q.size(), done_cnt - d0); end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [31:0] fs_a, fs_b;
    int d0, n_b;
    fs_a = 32'($urandom_range(60, 120));
    fs_b = 32'($urandom_range(60, 120));
    d0 = done_cnt;
    build_file(fs_a, $urandom, 1'b0);
    expect_writes(fs_a, beats.size() - 14);
    send_range(0, beats.size() - 1, 1'b0);
    #1;
    n_checks++; if (rx_done !== 1'b1 || mstr_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_done_cycle: got rx_done %b ready %b, required 1 and 0", rx_done, mstr_ready); end
    build_file(fs_b, $urandom, 1'b0);
    n_b = beats.size() - 14;
    send_beat(beats[0], 1'b1, 1'b0);
    #1;
    n_checks++; if (mem_addr !== 16'd0 || bytes_rcvd !== 32'd4 || src_id !== 1'b1) begin n_fail++; $display("FAIL b2b_word0: got addr %0d bytes %0d id %b, required 0, 4, 1", mem_addr, bytes_rcvd, src_id); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_first_file: got %0d writes owed, required 0", exp_q.size()); end
    expect_writes(fs_b, n_b);
    send_range(1, beats.size() - 1, 1'b1);
    settle();
    n_checks++; if (exp_q.size() != 0 || done_cnt - d0 != 2) begin n_fail++; $display("FAIL b2b_second_file: got %0d owed, %0d done, required 0 and 2", exp_q.size(), done_cnt - d0); end
    exp_q.delete();
  endtask

  task automatic test_boundaries();
    int d0, w0;
    // Shortest legal file: one payload byte; mstr_cmplt on its final beat is ignored.
    build_file(32'd57, $urandom, 1'b0);
    expect_writes(32'd57, 1);
    d0 = done_cnt;
    send_range(0, 13, 1'b0);
    send_beat(beats[14], 1'b0, 1'b1);
    settle();
    n_checks++; if (err_len !== 1'b0 || done_cnt - d0 != 1 || exp_q.size() != 0) begin n_fail++; $display("FAIL min_file: got err_len %b, %0d done, %0d owed, required 0, 1, 0", err_len, done_cnt - d0, exp_q.size()); end
    n_checks++; if (bytes_rcvd !== 32'd60) begin n_fail++; $display("FAIL min_file_bytes: got %0d, required 60", bytes_rcvd); end
    exp_q.delete();
    // Header-only file is too short.
    build_file(32'd56, $urandom, 1'b0);
    w0 = wr_cnt;
    send_range(0, 13, 1'b0);
    settle();
    n_checks++; if (err_len !== 1'b1 || fsm_state !== ST_ERROR || wr_cnt != w0 || bytes_rcvd !== 32'd56) begin n_fail++; $display("FAIL short_file: got err_len %b state %0d writes %0d bytes %0d, required 1, %0d, 0, 56", err_len, fsm_state, wr_cnt - w0, bytes_rcvd, ST_ERROR); end
    pulse_clr();
    // One byte more than the image memory holds.
    build_file(32'd56 + 32'd262145, $urandom, 1'b0);
    send_range(0, 13, 1'b0);
    settle();
    n_checks++; if (err_len !== 1'b1 || fsm_state !== ST_ERROR) begin n_fail++; $display("FAIL long_file: got err_len %b state %0d, required 1 and %0d", err_len, fsm_state, ST_ERROR); end
    pulse_clr();
  endtask

  task automatic test_reset_mid();
    // Exactly fills the image memory, so the header is accepted.
    build_file(32'd56 + 32'd262144, $urandom, 1'b0);
    expect_writes(32'd56 + 32'd262144, 3);
    send_range(0, 13, 1'b0);
    #1;
    n_checks++; if (fsm_state !== ST_PAYLOAD || err_len !== 1'b0) begin n_fail++; $display("FAIL max_file_hdr: got state %0d err_len %b, required %0d and 0", fsm_state, err_len, ST_PAYLOAD); end
    send_range(14, 16, 1'b0);
    #2;
    data_in = beats[17];
    mstr_data_valid = 2'b01;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({mstr_ready, mem_wr, rx_done, err_sig, err_len, err_src, src_id} !== 7'b0 || fsm_state !== ST_IDLE) begin n_fail++; $display("FAIL midreset_flags: got %b state %0d, required 0000000 and %0d", {mstr_ready, mem_wr, rx_done, err_sig, err_len, err_src, src_id}, fsm_state, ST_IDLE); end
    n_checks++; if ({mem_addr, mem_wdata, mem_be, file_size, data_offset, bytes_rcvd} !== 148'd0) begin n_fail++; $display("FAIL midreset_fields: got addr %0d size %0d bytes %0d, required all 0", mem_addr, file_size, bytes_rcvd); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL midreset_writes: got %0d owed, required 0", exp_q.size()); end
    exp_q.delete();
    @(negedge clk);
    mstr_data_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    settle();
  endtask

  initial begin
    rst_n = 1'b0;
    mstr_data_valid = 2'b00;
    data_in = 32'd0;
    mstr_cmplt = 1'b0;
    mem_full = 1'b0;
    clr = 1'b0;
    test_reset();
    test_nominal();
    test_random_files();
    test_bad_sig();
    test_early_cmplt();
    test_src_switch();
    test_backpressure();
    test_back_to_back();
    test_boundaries();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
